// File: rtl/unsigned_calc_seq_v_pkg.sv
// Shared definitions for the sequential KA*A - KB*B + KC*C calculator:
// state encoding, result-width helper and a behavioural reference.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two guard bits: one for the sum of the two positive terms, one for sign.
  function automatic int calc_owidth(input int width, input int kwidth);
    return width + kwidth + 2;
  endfunction

  function automatic int calc_ref(input int a, input int b, input int c,
                                  input int ka, input int kb, input int kc);
    return ka * a - kb * b + kc * c;
  endfunction

endpackage

// File: rtl/unsigned_calc_seq_v_ripple_add.sv
// Bit-level ripple-carry adder used by the shift-add step datapath.
module full_adder_v (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module ripple_add_v #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    full_adder_v u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (carry[gi]),
      .sum  (sum[gi]),
      .cout (carry[gi+1])
    );
  end

  assign cout = carry[N];
endmodule

// File: rtl/unsigned_calc_seq_v.sv
// Multi-cycle unsigned calculator: o_fu = KA*A - KB*B + KC*C, one coefficient
// bit retired per clock, valid/ready handshakes on both sides.
module unsigned_calc_seq_v
  import calc_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int KWIDTH = 3,
  parameter int KA     = 7,
  parameter int KB     = 3,
  parameter int KC     = 6,
  parameter int OWIDTH = calc_owidth(WIDTH, KWIDTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WIDTH-1:0]  i_au,
  input  logic [WIDTH-1:0]  i_bu,
  input  logic [WIDTH-1:0]  i_cu,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_flush,
  output logic [OWIDTH-1:0] o_fu,
  output logic              o_valid,
  input  logic              i_ready
);

  localparam int KIW = 4;
  localparam logic [KIW-1:0] K_LAST = KIW'(KWIDTH - 1);

  if (WIDTH < 1 || WIDTH > 16 || KWIDTH < 1 || KWIDTH > 8 ||
      KA < 0 || KA >= (1 << KWIDTH) ||
      KB < 0 || KB >= (1 << KWIDTH) ||
      KC < 0 || KC >= (1 << KWIDTH) ||
      OWIDTH != calc_owidth(WIDTH, KWIDTH)) begin : g_bad_params
    $fatal(1, "unsigned_calc_seq_v: parameter out of range");
  end

  localparam logic [KWIDTH-1:0] KA_VEC = KWIDTH'(KA);
  localparam logic [KWIDTH-1:0] KB_VEC = KWIDTH'(KB);
  localparam logic [KWIDTH-1:0] KC_VEC = KWIDTH'(KC);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic [OWIDTH-1:0]  acc_q, acc_d;
  logic [OWIDTH-1:0]  fu_q, fu_d;
  logic [KIW-1:0]     k_q, k_d;

  logic [KWIDTH-1:0]  ka_sh, kb_sh, kc_sh;
  logic [OWIDTH-1:0]  term_a, term_b_inv, term_c;
  logic [OWIDTH-1:0]  sum_ac, sum_acc, sum_step;
  logic [2:0]         unused_cout;

  // Select the current coefficient bit by shifting, so k_q may be wider
  // than the coefficient vector's index.
  always_comb begin
    ka_sh      = KA_VEC >> k_q;
    kb_sh      = KB_VEC >> k_q;
    kc_sh      = KC_VEC >> k_q;
    term_a     = ka_sh[0] ? (OWIDTH'(a_q) << k_q) : '0;
    term_c     = kc_sh[0] ? (OWIDTH'(c_q) << k_q) : '0;
    term_b_inv = ~(kb_sh[0] ? (OWIDTH'(b_q) << k_q) : '0);
  end

  ripple_add_v #(.N(OWIDTH)) u_add_ac (
    .a    (term_a),
    .b    (term_c),
    .cin  (1'b0),
    .sum  (sum_ac),
    .cout (unused_cout[0])
  );

  ripple_add_v #(.N(OWIDTH)) u_add_acc (
    .a    (acc_q),
    .b    (sum_ac),
    .cin  (1'b0),
    .sum  (sum_acc),
    .cout (unused_cout[1])
  );

  // Inverted term plus carry-in subtracts; a zero term inverts to all ones
  // and the carry wraps it back to zero.
  ripple_add_v #(.N(OWIDTH)) u_sub_b (
    .a    (sum_acc),
    .b    (term_b_inv),
    .cin  (1'b1),
    .sum  (sum_step),
    .cout (unused_cout[2])
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    k_d     = k_q;
    fu_d    = fu_q;

    if (i_flush) begin
      state_d = IDLE;
      acc_d   = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            a_d     = i_au;
            b_d     = i_bu;
            c_d     = i_cu;
            acc_d   = '0;
            k_d     = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          acc_d = sum_step;
          k_d   = k_q + KIW'(1);
          if (k_q == K_LAST) begin
            fu_d    = sum_step;
            k_d     = '0;
            state_d = DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      fu_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      fu_q    <= fu_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_fu    = fu_q;

endmodule
